// File: rtl/display_bcd_calculadora.sv
// display_bcd_calculadora - sequential double-dabble of an 8-bit value into three BCD digits
// driving a 3-digit multiplexed active-low 7-segment display.
module display_bcd_calculadora #(
  parameter int SCAN_DIV    = 50000,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] valor,
  output logic [3:0] centenas,
  output logic [3:0] dezenas,
  output logic [3:0] unidades,
  output logic       ocupado,
  output logic       pronto,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA} state_t;

  state_t           state;
  logic [7:0]       ultimo;
  logic [7:0]       shift;
  logic [11:0]      bcd;
  logic [11:0]      bcd_adj;
  logic [3:0]       count;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       idx;
  logic [3:0]       digit;
  logic             blank;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= OCIOSO;
      ultimo   <= 8'd0;
      shift    <= 8'd0;
      bcd      <= 12'd0;
      count    <= 4'd0;
      centenas <= 4'd0;
      dezenas  <= 4'd0;
      unidades <= 4'd0;
      ocupado  <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (state)
        OCIOSO: begin
          if (valor != ultimo) begin
            shift   <= valor;
            bcd     <= 12'd0;
            count   <= 4'd0;
            ultimo  <= valor;
            ocupado <= 1'b1;
            state   <= CONVERTE;
          end
        end
        CONVERTE: begin
          {bcd, shift} <= {bcd_adj, shift} << 1;
          count        <= count + 4'd1;
          if (count == 4'd7) state <= ATUALIZA;
        end
        ATUALIZA: begin
          centenas <= bcd[11:8];
          dezenas  <= bcd[7:4];
          unidades <= bcd[3:0];
          pronto   <= 1'b1;
          ocupado  <= 1'b0;
          state    <= OCIOSO;
        end
        default: state <= OCIOSO;
      endcase
    end
  end

  // Display scan free-runs regardless of conversion activity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      idx     <= 2'd0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      idx     <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    digit = unidades;
    blank = 1'b0;
    an    = 3'b110;
    case (idx)
      2'd1: begin
        digit = dezenas;
        blank = BLANK_ZEROS && (centenas == 4'd0) && (dezenas == 4'd0);
        an    = 3'b101;
      end
      2'd2: begin
        digit = centenas;
        blank = BLANK_ZEROS && (centenas == 4'd0);
        an    = 3'b011;
      end
      default: ;
    endcase
    seg = blank ? 7'b1111111 : seg7(digit);
  end

endmodule

// File: tb/tb_display_bcd_calculadora.sv
// tb_display_bcd_calculadora - decimal-arithmetic model checked every cycle plus directed literal checks.
module tb_display_bcd_calculadora;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] valor = 8'd0;
  logic [3:0] centenas, dezenas, unidades;
  logic       ocupado, pronto;
  logic [6:0] seg;
  logic [2:0] an;

  int total = 0;
  int bad   = 0;

  display_bcd_calculadora #(.SCAN_DIV(SD), .BLANK_ZEROS(1'b1)) dut (
    .clk(clk), .rst(rst), .valor(valor),
    .centenas(centenas), .dezenas(dezenas), .unidades(unidades),
    .ocupado(ocupado), .pronto(pronto), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tbl[d];
  endfunction

  // Behavioural model: a value seen differing from the last captured one is
  // converted 9 clocks later with plain decimal arithmetic.
  int m_last, m_busy, m_val, m_cen, m_dez, m_uni, m_t;
  bit m_pronto;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_last = 0; m_busy = 0; m_val = 0; m_cen = 0; m_dez = 0; m_uni = 0;
      m_t = 0; m_pronto = 0;
    end else begin
      m_pronto = 0;
      m_t++;
      if (m_busy == 0) begin
        if (int'(valor) != m_last) begin
          m_last = valor; m_val = valor; m_busy = 9;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_cen = m_val / 100; m_dez = (m_val / 10) % 10; m_uni = m_val % 10;
          m_pronto = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int k;
    logic [2:0] e_an;
    logic [6:0] e_seg;
    k = (m_t / SD) % 3;
    if (k == 0) begin
      e_an = 3'b110; e_seg = seg_of(m_uni);
    end else if (k == 1) begin
      e_an = 3'b101; e_seg = (m_cen == 0 && m_dez == 0) ? 7'b1111111 : seg_of(m_dez);
    end else begin
      e_an = 3'b011; e_seg = (m_cen == 0) ? 7'b1111111 : seg_of(m_cen);
    end
    check("m_ocupado", 32'(ocupado), 32'(m_busy != 0));
    check("m_pronto", 32'(pronto), 32'(m_pronto));
    check("m_digits", {20'd0, centenas, dezenas, unidades}, 32'((m_cen << 8) | (m_dez << 4) | m_uni));
    check("m_an", 32'(an), 32'(e_an));
    check("m_seg", 32'(seg), 32'(e_seg));
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Waits for pronto, counting negedges with ocupado high on the way.
  task automatic run_conv(output int busy, output int at);
    busy = 0; at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ocupado) busy++;
      if (pronto) begin at = cyc; break; end
    end
    if (at < 0) check("pronto_timeout", 32'd0, 32'd1);
  endtask

  // Aligns to the start of the units slot, then records an/seg for one full scan.
  task automatic grab_scan(output logic [2:0] ans [12], output logic [6:0] segs [12]);
    logic [2:0] prev;
    bit found;
    prev = an; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (an == 3'b110 && prev == 3'b011) found = 1;
      else prev = an;
    end
    if (!found) check("scan_align_timeout", 32'd0, 32'd1);
    ans[0] = an; segs[0] = seg;
    for (int i = 1; i < 12; i++) begin
      @(negedge clk);
      ans[i] = an; segs[i] = seg;
    end
  endtask

  initial begin
    int busy, p1, p2;
    bit seen_busy, seen_pronto;
    logic [2:0] ans [12];
    logic [6:0] segs [12];

    // 1: reset values and idle with valor=0
    #2;
    check("rst_an", 32'(an), 32'(3'b110));
    check("rst_seg", 32'(seg), 32'(7'b1000000));
    check("rst_ocupado", 32'(ocupado), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    seen_busy = 0; seen_pronto = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen_busy |= ocupado; seen_pronto |= pronto;
    end
    check("idle_no_busy", 32'(seen_busy), 32'd0);
    check("idle_no_pronto", 32'(seen_pronto), 32'd0);

    // 2: 255
    valor = 8'd255;
    run_conv(busy, p1);
    check("c255_busy_cycles", 32'(busy), 32'd9);
    check("c255_digits", {20'd0, centenas, dezenas, unidades}, 32'h255);
    @(negedge clk);
    check("c255_pronto_one_cycle", 32'(pronto), 32'd0);

    // 3: 128 then 7 on third ocupado cycle
    valor = 8'd128;
    for (int i = 0; i < 5 && !ocupado; i++) @(negedge clk);
    check("c128_started", 32'(ocupado), 32'd1);
    @(negedge clk); @(negedge clk);
    valor = 8'd7;
    run_conv(busy, p1);
    check("c128_digits", {20'd0, centenas, dezenas, unidades}, 32'h128);
    run_conv(busy, p2);
    check("c7_digits", {20'd0, centenas, dezenas, unidades}, 32'h007);
    check("c7_pronto_gap", 32'(p2 - p1), 32'd10);

    // 4: scan pattern with blanking for 7
    grab_scan(ans, segs);
    for (int i = 0; i < 12; i++) begin
      check("scan7_an", 32'(ans[i]), (i < 4) ? 32'(3'b110) : (i < 8) ? 32'(3'b101) : 32'(3'b011));
      check("scan7_seg", 32'(segs[i]), (i < 4) ? 32'(7'b1111000) : 32'(7'b1111111));
    end

    // 5: 105, inner zero stays visible
    @(negedge clk);
    valor = 8'd105;
    run_conv(busy, p1);
    grab_scan(ans, segs);
    check("c105_units", 32'(segs[0]), 32'(7'b0010010));
    check("c105_tens", 32'(segs[4]), 32'(7'b1000000));
    check("c105_hund", 32'(segs[8]), 32'(7'b1111001));

    // 6: async reset mid-conversion, then 42
    @(negedge clk);
    valor = 8'd200;
    for (int i = 0; i < 5 && !ocupado; i++) @(negedge clk);
    @(negedge clk); @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("arst_ocupado", 32'(ocupado), 32'd0);
    check("arst_digits", {20'd0, centenas, dezenas, unidades}, 32'h000);
    check("arst_an", 32'(an), 32'(3'b110));
    check("arst_seg", 32'(seg), 32'(7'b1000000));
    @(negedge clk);
    valor = 8'd42;
    @(negedge clk);
    rst = 1'b1;
    run_conv(busy, p1);
    check("c42_busy_cycles", 32'(busy), 32'd9);
    check("c42_digits", {20'd0, centenas, dezenas, unidades}, 32'h042);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_bcd_calculadora.md
Name: display_bcd_calculadora

Overview:
Downstream stage of the synchronous calculator. Consumes its 8-bit result (saida) and converts it sequentially to three BCD digits using shift-add-3 (double dabble). Drives a 3-digit multiplexed 7-segment display with active-low anodes and segments. Also exports the stable BCD digits and a conversion-done pulse for other consumers.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays lit (≥2)
BLANK_ZEROS, 1, 1 = blank leading zeros on centenas/dezenas; 0 = show all digits

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted at 0)
valor  input  8  unsigned value to display (calculator saida)
centenas  output  4  stable hundreds digit
dezenas  output  4  stable tens digit
unidades  output  4  stable units digit
ocupado  output  1  high while a conversion is in progress
pronto  output  1  one-cycle pulse when digit registers update
seg  output  7  segments, active-low, seg[6:0]=g,f,e,d,c,b,a
an  output  3  anodes, active-low one-hot; an[0]=unidades, an[1]=dezenas, an[2]=centenas

Behaviour:
- Reset (rst=0, async): state OCIOSO; ultimo=0; shift/BCD work regs=0; centenas/dezenas/unidades=0; ocupado=0; pronto=0; scan counter=0; digit index=0; an=3'b110; seg=7'b1000000.
- Reset while converting aborts the conversion. Nothing is retained.
- FSM states: OCIOSO, CONVERTE, ATUALIZA. ocupado=1 in CONVERTE and ATUALIZA.
- OCIOSO: on an edge with valor≠ultimo:
  - load shift reg←valor, bcd←12'b0, bit count←0, ultimo←valor;
  - go to CONVERTE.
  - If valor==ultimo, stay. After reset, valor=0 triggers nothing.
- CONVERTE: per edge:
  - add 3 to each BCD nibble ≥5;
  - shift {bcd,shift} left by 1;
  - increment count.
  - After the 8th shift, go to ATUALIZA.
- ATUALIZA: on the next edge, load centenas/dezenas/unidades from bcd, set pronto=1, go to OCIOSO. pronto clears on the following edge.
- Latency: capture edge E0, shifts E1..E8, digit update plus pronto at E9. ocupado is high for 9 cycles.
- valor changes during a conversion are ignored. On return to OCIOSO, valor is compared against ultimo, so the final stable value is always converted (worst case 18 cycles).
- Digit outputs change only at ATUALIZA and never show partial results.
- Scan:
  - div counter runs 0..SCAN_DIV-1;
  - at SCAN_DIV-1 it wraps to 0 and the digit index advances 0→1→2→0;
  - an per index: 0→3'b110, 1→3'b101, 2→3'b011;
  - seg updates in the same cycle as an.
  - The scan runs continuously, independent of the FSM.
- Segment map (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001;
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Blanking (BLANK_ZEROS=1):
  - centenas is blanked if it is 0;
  - dezenas is blanked if both centenas and dezenas are 0;
  - unidades is never blanked;
  - a blanked digit drives seg=7'b1111111, and its anode still cycles.
- Arithmetic: 8-bit unsigned, range 0..255, so centenas ≤2. There is no overflow case.

Test Plan:
1. Reset release with valor=0 → ocupado stays 0, pronto never pulses, digits 0/0/0, an=110, seg=1000000.
2. valor=255 → ocupado high for 9 cycles; at E9 pronto pulses once; digits 2/5/5.
3. valor=128, then valor=7 on the 3rd cycle of ocupado → first pronto with 1/2/8. Reconversion starts automatically; second pronto with 0/0/7 exactly 10 cycles after the first.
4. SCAN_DIV=4, BLANK_ZEROS=1, valor=7 converted → an cycles 110,101,011 with 4 cycles each; seg=1111000 on an=110 and 1111111 on the other two digits.
5. BLANK_ZEROS=1, valor=105 → an=101 shows seg=1000000 (dezenas 0 not blanked), an=011 shows 1111001, an=110 shows 0010010.
6. Assert rst=0 mid-CONVERTE (valor=200) → outputs return to reset values immediately, without waiting for a clock edge. Release with valor=42 stable → ocupado for 9 cycles, then digits 0/4/2 plus pronto.
